alu_arbiter: RTL and testbench

//   Shares the single ALU between two requesters (req0 = execute stage, req1 = address/branch unit).

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// holding operands for multi-cycle multiply and keeping the response until it is accepted.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shift,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shift,
  output logic [3:0]       alu_optcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             resp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0] sh_q, sh_d;
  logic id_q, id_d, err_q, err_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0] flg_q, flg_d;
  logic g0, g1, acc, gid, bad;
  logic [3:0] sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [4:0] sel_sh;
  // last_q names the previous winner, so the other requester wins a tie
  assign g0 = req0_valid && (!req1_valid || last_q);
  assign g1 = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = (state_q == IDLE) && g0;
  assign req1_ready = (state_q == IDLE) && g1;
  assign acc = req0_ready || req1_ready;
  assign gid = req1_ready;
  assign sel_op = gid ? req1_op : req0_op;
  assign sel_a = gid ? req1_a : req0_a;
  assign sel_b = gid ? req1_b : req0_b;
  assign sel_sh = gid ? req1_shift : req0_shift;
  assign bad = sel_op > 4'd9;
  assign alu_optcode = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_shift = sh_q;
  assign resp_valid = state_q == RESP;
  assign resp_id = id_q;
  assign resp_result = res_q;
  assign resp_flags = flg_q;
  assign resp_err = err_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    sh_d = sh_q;
    id_d = id_q;
    err_d = err_q;
    res_d = res_q;
    flg_d = flg_q;
    case (state_q)
      IDLE: if (acc) begin
        last_d = gid;
        id_d = gid;
        if (bad) begin
          res_d = '0;
          flg_d = 4'b0000;
          err_d = 1'b1;
          state_d = RESP;
        end else begin
          op_d = sel_op;
          a_d = sel_a;
          b_d = sel_b;
          sh_d = sel_sh;
          cnt_d = sel_op == 4'd2 ? 4'(MUL_CYCLES - 1) : 4'd0;
          state_d = EXEC;
        end
      end
      EXEC: if (cnt_q == 4'd0) begin
        res_d = alu_result;
        flg_d = alu_flags;
        err_d = 1'b0;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sh_q <= '0;
      id_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      sh_q <= sh_d;
      id_q <= id_d;
      err_q <= err_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors against alu_arbiter with a stand-in combinational ALU.
module tb_alu_arbiter;
  logic clk = 0, reset = 1;
  logic req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
  logic [3:0] req0_op = 0, req1_op = 0, alu_optcode, alu_flags, resp_flags;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [4:0] req0_shift = 0, req1_shift = 0, alu_shift;
  logic [31:0] alu_a, alu_b, alu_result, resp_result;
  logic resp_valid, resp_ready = 0, resp_id, resp_err;
  int n_vec = 0, n_err = 0;

  alu_arbiter #(.WIDTH(32), .MUL_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
    .alu_optcode(alu_optcode), .alu_a(alu_a), .alu_b(alu_b), .alu_shift(alu_shift),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // stand-in ALU: n and z flags only
  always_comb begin
    case (alu_optcode)
      4'd0: alu_result = alu_a + alu_b;
      4'd1, 4'd9: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a * alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a & alu_b;
      4'd5: alu_result = alu_a ^ alu_b;
      4'd6: alu_result = alu_a >> alu_shift;
      4'd7: alu_result = alu_a << alu_shift;
      default: alu_result = (alu_a >> alu_shift) | (alu_a << (6'd32 - {1'b0, alu_shift}));
    endcase
    alu_flags = {alu_result[31], alu_result == 32'd0, 2'b00};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", resp_valid, 0);
    check("rst_result", resp_result, 0);
    check("rst_op", alu_optcode, 0);
    check("rst_a", alu_a, 0);
    reset = 0;
    // single add from req0
    @(negedge clk);
    req0_valid = 1; req0_op = 0; req0_a = 5; req0_b = 1;
    #1 check("add_rdy", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 0;
    check("add_exec_valid", resp_valid, 0);
    check("add_alu_a", alu_a, 5);
    @(negedge clk);
    check("add_valid", resp_valid, 1);
    check("add_result", resp_result, 6);
    check("add_flags", resp_flags, 4'b0000);
    check("add_id", resp_id, 0);
    check("add_err", resp_err, 0);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    check("add_done", resp_valid, 0);
    // multiply from req1, held for three cycles
    req1_valid = 1; req1_op = 2; req1_a = 5; req1_b = 2;
    #1 check("mul_rdy", {req0_ready, req1_ready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req1_valid = 0;
      check("mul_op_held", alu_optcode, 2);
      check("mul_wait", resp_valid, 0);
    end
    @(negedge clk);
    check("mul_valid", resp_valid, 1);
    check("mul_result", resp_result, 10);
    check("mul_id", resp_id, 1);
    resp_ready = 1;
    // both requesting continuously: one accept per three cycles, alternating
    @(negedge clk);
    req0_valid = 1; req0_op = 0; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_op = 3; req1_a = 4; req1_b = 8;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1 check("rr_rdy", {req0_ready, req1_ready},
               i % 3 != 0 ? 2'b00 : ((i / 3) % 2 == 0 ? 2'b10 : 2'b01));
      check("rr_valid", resp_valid, i % 3 == 2);
      if (i % 3 == 2) begin
        check("rr_id", resp_id, (i / 3) % 2);
        check("rr_result", resp_result, (i / 3) % 2 == 0 ? 2 : 12);
      end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    // cmp response stalled by the consumer
    @(negedge clk);
    req0_valid = 1; req0_op = 9; req0_a = 11; req0_b = 11;
    #1 check("cmp_rdy", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_op = 0; req1_a = 1; req1_b = 2;
    #1 check("cmp_exec_r1", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) resp_ready = 1;
      #1 check("cmp_valid", resp_valid, 1);
      check("cmp_flags", resp_flags, 4'b0100);
      check("cmp_result", resp_result, 0);
      check("cmp_r1_blocked", req1_ready, 0);
    end
    @(negedge clk);
    resp_ready = 0;
    #1 check("after_hs_r1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    check("r1_add_result", resp_result, 3);
    check("r1_add_id", resp_id, 1);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    // illegal opcode
    req0_valid = 1; req0_op = 4'b1100; req0_a = 7; req0_b = 7;
    #1 check("ill_rdy", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0;
    check("ill_valid", resp_valid, 1);
    check("ill_err", resp_err, 1);
    check("ill_result", resp_result, 0);
    check("ill_flags", resp_flags, 4'b0000);
    check("ill_id", resp_id, 0);
    check("ill_op_kept", alu_optcode, 0);
    check("ill_a_kept", alu_a, 1);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    // reset during multiply
    req1_valid = 1; req1_op = 2; req1_a = 3; req1_b = 3;
    #1 check("rmul_rdy", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    check("rmul_op", alu_optcode, 2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rmul_valid", resp_valid, 0);
    check("rmul_op_clr", alu_optcode, 0);
    req0_valid = 1; req0_op = 0; req0_a = 2; req0_b = 2;
    req1_valid = 1; req1_op = 0;
    #1 check("rmul_rdy_after", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    check("rmul_no_resp", resp_valid, 0);
    @(negedge clk);
    check("post_rst_valid", resp_valid, 1);
    check("post_rst_result", resp_result, 4);
    check("post_rst_id", resp_id, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
